// File: rtl/lcd_fb_packer_if.sv
// Pixel write stream from the PPU MMIO wrapper into the framebuffer packer.
interface lcd_fb_packer_if;
  logic [1:0]  pix_in;
  logic [15:0] pix_a;
  logic        pix_wr;
  logic        vblank;

  modport master (output pix_in, output pix_a, output pix_wr, output vblank);
  modport slave  (input  pix_in, input  pix_a, input  pix_wr, input  vblank);
endinterface

// File: rtl/lcd_fb_packer.sv
// Packs 2-bit PPU pixels four to a byte and writes them into the back bank of
// a double-banked framebuffer; swaps banks on scan-out vsync once a full
// frame has been flushed.
module lcd_fb_packer #(
  parameter int unsigned H_RES = 160,
  parameter int unsigned V_RES = 144,
  parameter int unsigned FB_AW = 13
) (
  input  logic                clk,
  input  logic                rst,
  lcd_fb_packer_if.slave      px,
  input  logic                disp_vsync,
  output logic [FB_AW:0]      fb_a,
  output logic [7:0]          fb_din,
  output logic [3:0]          fb_mask,
  output logic                fb_we,
  output logic                front_bank,
  output logic                frame_ready,
  output logic [7:0]          drop_px,
  output logic [7:0]          drop_frames
);

  localparam int unsigned NPIX = H_RES * V_RES;

  typedef struct packed {
    logic [FB_AW-1:0] word;
    logic [7:0]       data;
    logic [3:0]       mask;
  } wr_t;

  wr_t  acc, nxt_acc;
  logic acc_valid, nxt_valid;
  wr_t  pend;
  logic pend_valid;
  logic closing;

  logic             in_range, out_of_range;
  logic [FB_AW-1:0] pix_word;
  logic [1:0]       pix_lane;

  wr_t  wp, wv, issue, second;
  logic wp_v, wv_v, issue_v, second_v;
  logic close_now, close_start, close_done, swap;

  assign in_range     = px.pix_wr && ({16'd0, px.pix_a} < NPIX);
  assign out_of_range = px.pix_wr && !({16'd0, px.pix_a} < NPIX);
  assign pix_word     = px.pix_a[FB_AW+1:2];
  assign pix_lane     = px.pix_a[1:0];

  // Merge the incoming pixel, then apply vblank; collect up to two new writes
  // and order them behind any write already waiting in the pending slot.
  always_comb begin
    nxt_acc   = acc;
    nxt_valid = acc_valid;
    wp_v      = 1'b0;
    wp        = '0;
    wv_v      = 1'b0;
    wv        = '0;
    issue_v   = 1'b0;
    issue     = '0;
    second_v  = 1'b0;
    second    = '0;

    if (in_range) begin
      if (acc_valid && (acc.word != pix_word)) begin
        wp_v      = 1'b1;
        wp        = acc;
        nxt_valid = 1'b0;
      end
      if (!nxt_valid) begin
        nxt_acc      = '0;
        nxt_acc.word = pix_word;
      end
      nxt_acc.data[{pix_lane, 1'b0} +: 2] = px.pix_in;
      nxt_acc.mask[pix_lane]              = 1'b1;
      nxt_valid                           = 1'b1;
      // A freshly started word holds one lane, so it never completes here
      // at the same time as a word-change write.
      if (&nxt_acc.mask) begin
        wp_v      = 1'b1;
        wp        = nxt_acc;
        nxt_acc   = '0;
        nxt_valid = 1'b0;
      end
    end

    if (px.vblank && nxt_valid) begin
      wv_v      = 1'b1;
      wv        = nxt_acc;
      nxt_acc   = '0;
      nxt_valid = 1'b0;
    end

    if (pend_valid) begin
      issue_v  = 1'b1;
      issue    = pend;
      second_v = wp_v || wv_v;
      second   = wp_v ? wp : wv;
    end else if (wp_v) begin
      issue_v  = 1'b1;
      issue    = wp;
      second_v = wv_v;
      second   = wv;
    end else if (wv_v) begin
      issue_v  = 1'b1;
      issue    = wv;
    end
  end

  // A vblank with nothing left to write closes the frame at once; otherwise
  // the close waits until the pending slot has drained.
  assign close_now   = px.vblank && !frame_ready && !wp_v && !wv_v && !pend_valid;
  assign close_start = px.vblank && !close_now;
  assign close_done  = closing && !pend_valid;
  assign swap        = disp_vsync && frame_ready;

  // Accumulator, pending slot and registered framebuffer write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      acc_valid  <= 1'b0;
      pend       <= '0;
      pend_valid <= 1'b0;
      fb_we      <= 1'b0;
      fb_a       <= '0;
      fb_din     <= '0;
      fb_mask    <= '0;
    end else begin
      acc        <= nxt_acc;
      acc_valid  <= nxt_valid;
      pend       <= second;
      pend_valid <= second_v;
      fb_we      <= issue_v;
      if (issue_v) begin
        fb_a    <= {~front_bank, issue.word};
        fb_din  <= issue.data;
        fb_mask <= issue.mask;
      end
    end
  end

  // Frame close, bank swap on scan-out vsync, and overwrite detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      closing     <= 1'b0;
      frame_ready <= 1'b0;
      front_bank  <= 1'b0;
      drop_frames <= '0;
    end else begin
      if (close_start)     closing <= 1'b1;
      else if (close_done) closing <= 1'b0;

      if (swap) begin
        front_bank  <= ~front_bank;
        frame_ready <= 1'b0;
      end else if (px.vblank && frame_ready) begin
        frame_ready <= 1'b0;
        if (drop_frames != 8'hFF) drop_frames <= drop_frames + 8'd1;
      end

      if (close_now || close_done) frame_ready <= 1'b1;
    end
  end

  // Saturating count of pixel writes outside the visible frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_px <= '0;
    end else if (out_of_range && (drop_px != 8'hFF)) begin
      drop_px <= drop_px + 8'd1;
    end
  end

endmodule

// File: tb/tb_lcd_fb_packer.sv
// Self-checking bench for lcd_fb_packer: directed scenarios plus randomized
// frames checked against a pixel-image reference model.
module tb_lcd_fb_packer;

  logic        clk;
  logic        rst;
  logic        disp_vsync;
  logic [13:0] fb_a;
  logic [7:0]  fb_din;
  logic [3:0]  fb_mask;
  logic        fb_we;
  logic        front_bank;
  logic        frame_ready;
  logic [7:0]  drop_px;
  logic [7:0]  drop_frames;

  int tests;
  int fails;
  int wr_count;

  logic [7:0] mem [16384];

  lcd_fb_packer_if pif ();

  lcd_fb_packer #(.H_RES(160), .V_RES(144), .FB_AW(13)) dut (
    .clk         (clk),
    .rst         (rst),
    .px          (pif),
    .disp_vsync  (disp_vsync),
    .fb_a        (fb_a),
    .fb_din      (fb_din),
    .fb_mask     (fb_mask),
    .fb_we       (fb_we),
    .front_bank  (front_bank),
    .frame_ready (frame_ready),
    .drop_px     (drop_px),
    .drop_frames (drop_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM model fed by the write port.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      for (int k = 0; k < 4; k++)
        if (fb_mask[k]) mem[fb_a][2*k +: 2] = fb_din[2*k +: 2];
      wr_count++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pif.pix_wr = 1'b0;
    pif.vblank = 1'b0;
    disp_vsync = 1'b0;
  endtask

  task automatic set_pix(input int a, input logic [1:0] v);
    pif.pix_wr = 1'b1;
    pif.pix_a  = 16'(a);
    pif.pix_in = v;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
  endtask

  task automatic check_wr(input string name, input logic [13:0] a,
                          input logic [7:0] d, input logic [3:0] m);
    tests++;
    if ({fb_we, fb_a, fb_din, fb_mask} !== {1'b1, a, d, m}) begin
      fails++;
      $display("FAIL %s: got we=%b a=%h din=%h mask=%h, want we=1 a=%h din=%h mask=%h",
               name, fb_we, fb_a, fb_din, fb_mask, a, d, m);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #1;
    tests++;
    if ({fb_we, fb_a, fb_din, fb_mask, front_bank, frame_ready, drop_px, drop_frames} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b a=%h din=%h mask=%h fb=%b fr=%b dpx=%0d dfr=%0d, want all 0",
               fb_we, fb_a, fb_din, fb_mask, front_bank, frame_ready, drop_px, drop_frames);
    end
    do_reset();
  endtask

  task automatic test_pack_word();
    logic [1:0] vals [4];
    vals[0] = 2'd1; vals[1] = 2'd2; vals[2] = 2'd3; vals[3] = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_pix(i, vals[i]);
      cyc();
      if (i < 3) check_bit("pack_no_early_we", fb_we, 1'b0);
    end
    check_wr("pack_word0", 14'h2000, 8'h39, 4'hF);
    idle();
    cyc();
    check_bit("pack_single_write", fb_we, 1'b0);
  endtask

  task automatic test_word_change();
    logic [1:0] v;
    v = 2'($urandom_range(0, 3));
    do_reset();
    set_pix(5, 2'd3);
    cyc();
    set_pix(12, v);
    cyc();
    check_wr("word_change_old", 14'h2001, 8'h0C, 4'h2);
    idle();
    pif.vblank = 1'b1;
    cyc();
    check_wr("word_change_new_flush", 14'h2003, {6'd0, v}, 4'h1);
    idle();
    cyc();
    check_bit("word_change_ready", frame_ready, 1'b1);
  endtask

  task automatic test_drop();
    int wc;
    do_reset();
    wc = wr_count;
    set_pix(23040, 2'd1);
    cyc();
    check_bit("drop_first_no_we", fb_we, 1'b0);
    set_pix(16'hFFFF, 2'd2);
    cyc();
    check_bit("drop_second_no_we", fb_we, 1'b0);
    idle();
    cyc();
    tests++;
    if (drop_px !== 8'd2) begin
      fails++;
      $display("FAIL drop_px_two: got %0d, want 2", drop_px);
    end
    for (int i = 0; i < 298; i++) begin
      set_pix(int'($urandom_range(65535, 23040)), 2'($urandom_range(0, 3)));
      cyc();
    end
    idle();
    cyc();
    tests++;
    if (drop_px !== 8'd255 || wr_count != wc) begin
      fails++;
      $display("FAIL drop_px_saturate: got drop_px=%0d writes=%0d, want 255 and 0 writes",
               drop_px, wr_count - wc);
    end
    set_pix(23039, 2'd2);
    cyc();
    idle();
    pif.vblank = 1'b1;
    cyc();
    check_wr("last_pixel", 14'h367F, 8'h80, 4'h8);
    idle();
  endtask

  task automatic test_vblank_flush_swap();
    logic [1:0] v;
    v = 2'($urandom_range(0, 3));
    do_reset();
    set_pix(8, v);
    cyc();
    idle();
    pif.vblank = 1'b1;
    cyc();
    check_wr("vblank_flush", 14'h2002, {6'd0, v}, 4'h1);
    check_bit("vblank_ready_not_yet", frame_ready, 1'b0);
    idle();
    cyc();
    check_bit("vblank_ready_set", frame_ready, 1'b1);
    repeat (8) cyc();
    check_bit("ready_held", frame_ready, 1'b1);
    check_bit("front_before_swap", front_bank, 1'b0);
    disp_vsync = 1'b1;
    cyc();
    idle();
    check_bit("front_after_swap", front_bank, 1'b1);
    check_bit("ready_after_swap", frame_ready, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] v1, v2;
    v1 = 2'($urandom_range(0, 3));
    v2 = 2'($urandom_range(0, 3));
    do_reset();
    set_pix(8, v1);
    cyc();
    set_pix(16, v2);
    pif.vblank = 1'b1;
    cyc();
    idle();
    check_wr("b2b_first", 14'h2002, {6'd0, v1}, 4'h1);
    check_bit("b2b_ready_low1", frame_ready, 1'b0);
    cyc();
    check_wr("b2b_second", 14'h2004, {6'd0, v2}, 4'h1);
    check_bit("b2b_ready_low2", frame_ready, 1'b0);
    cyc();
    check_bit("b2b_ready", frame_ready, 1'b1);
    check_bit("b2b_no_third", fb_we, 1'b0);
  endtask

  task automatic test_swap_race();
    do_reset();
    pif.vblank = 1'b1;
    disp_vsync = 1'b1;
    cyc();
    idle();
    check_bit("race_ready", frame_ready, 1'b1);
    check_bit("race_no_swap", front_bank, 1'b0);
    cyc();
    disp_vsync = 1'b1;
    cyc();
    idle();
    check_bit("race_swap_later", front_bank, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_pix(i, 2'd3);
      cyc();
    end
    idle();
    check_wr("bank0_write", 14'h0000, 8'hFF, 4'hF);
  endtask

  task automatic test_drop_frame_reset();
    int wc;
    do_reset();
    pif.vblank = 1'b1;
    cyc();
    idle();
    check_bit("empty_vblank_ready", frame_ready, 1'b1);
    cyc();
    pif.vblank = 1'b1;
    cyc();
    idle();
    repeat (3) cyc();
    tests++;
    if (drop_frames !== 8'd1 || front_bank !== 1'b0) begin
      fails++;
      $display("FAIL drop_frames: got drop_frames=%0d front=%b, want 1 and 0",
               drop_frames, front_bank);
    end
    set_pix(1, 2'd2);
    cyc();
    set_pix(2, 2'd1);
    #2;
    wc = wr_count;
    rst = 1'b0;
    #1;
    tests++;
    if ({fb_we, fb_a, fb_din, fb_mask, front_bank, frame_ready, drop_px, drop_frames} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got we=%b a=%h fb=%b fr=%b dfr=%0d, want all 0",
               fb_we, fb_a, front_bank, frame_ready, drop_frames);
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) cyc();
    tests++;
    if (wr_count != wc) begin
      fails++;
      $display("FAIL no_stray_write: got %0d writes, want 0", wr_count - wc);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_img [int];
    int exp_drop, cur, r, b, widx;
    logic exp_front;
    logic [1:0] v, got;
    do_reset();
    exp_drop  = 0;
    exp_front = 1'b0;
    for (int f = 0; f < 3; f++) begin
      b = exp_front ? 0 : 1;
      for (int a = 0; a < 8192; a++) mem[b*8192 + a] = 'x;
      exp_img.delete();
      cur = int'($urandom_range(0, 22900));
      for (int n = 0; n < 120; n++) begin
        r = int'($urandom_range(0, 99));
        v = 2'($urandom_range(0, 3));
        if (r < 8) begin
          idle();
        end else if (r < 13) begin
          set_pix(int'($urandom_range(65535, 23040)), v);
          exp_drop++;
        end else begin
          if (r < 25) cur = int'($urandom_range(0, 23039));
          else if (r >= 32) cur = (cur + 1) % 23040;
          set_pix(cur, v);
          exp_img[cur] = v;
        end
        cyc();
      end
      idle();
      pif.vblank = 1'b1;
      cyc();
      idle();
      for (int i = 0; i < 8 && frame_ready !== 1'b1; i++) cyc();
      check_bit("rand_ready", frame_ready, 1'b1);
      cyc();
      foreach (exp_img[idx]) begin
        widx = b*8192 + idx/4;
        got  = mem[widx][2*(idx%4) +: 2];
        tests++;
        if (got !== exp_img[idx]) begin
          fails++;
          $display("FAIL rand_pixel: frame %0d pixel %0d got %b, want %b",
                   f, idx, got, exp_img[idx]);
        end
      end
      disp_vsync = 1'b1;
      cyc();
      idle();
      exp_front = ~exp_front;
      check_bit("rand_front", front_bank, exp_front);
    end
    tests++;
    if (drop_px !== 8'((exp_drop > 255) ? 255 : exp_drop)) begin
      fails++;
      $display("FAIL rand_drop_px: got %0d, want %0d", drop_px, (exp_drop > 255) ? 255 : exp_drop);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    wr_count   = 0;
    rst        = 1'b1;
    pif.pix_in = '0;
    pif.pix_a  = '0;
    idle();
    cyc();
    test_reset();
    test_pack_word();
    test_word_change();
    test_drop();
    test_vblank_flush_swap();
    test_back_to_back();
    test_swap_race();
    test_drop_frame_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
